// File: rtl/ddu_pkg.sv
// Shared types and default timing for the debug display unit front-panel controller.
package ddu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STEP     = 2'd1,
        ST_WAIT_REL = 2'd2,
        ST_CONT     = 2'd3
    } run_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 50_000_000;
    localparam int DEF_REPEAT_PERIOD   = 25_000_000;
    localparam int DEF_ADDR_W          = 8;

endpackage

// File: rtl/btn_debounce.sv
// Raw board input conditioner: 2-FF synchroniser, stable-count debouncer and
// one-cycle rise pulse aligned with the first high cycle of the debounced level.
module btn_debounce
    import ddu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic db_o,
    output logic rise_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The count only survives while every sample disagrees with the current level.
    always_comb begin
        sync1_d = raw_i;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        rise_d = db_d & ~db_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db_o   = db_q;
    assign rise_o = rise_q;

endmodule

// File: rtl/ddu_ctrl.sv
// Front-panel controller: debounced switches, run/single-step sequencing and the
// debug view address. Define AUTO_REPEAT_EN to enable hold-to-repeat on inc/dec.
module ddu_ctrl
    import ddu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int ADDR_W          = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cont_sw,
    input  logic              step_btn,
    input  logic              inc_btn,
    input  logic              dec_btn,
    input  logic              load_btn,
    input  logic [ADDR_W-1:0] init_addr,
    output logic              run_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [15:0]       step_cnt_o,
    output logic [1:0]        mode_o
);

    logic cont_db, step_db, inc_db, dec_db;
    logic step_rise, inc_rise, dec_rise, load_rise;
    logic unused_cont_rise, unused_load_db;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cont (
        .clk(clk), .rst_n(rst_n), .raw_i(cont_sw), .db_o(cont_db), .rise_o(unused_cont_rise));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk(clk), .rst_n(rst_n), .raw_i(step_btn), .db_o(step_db), .rise_o(step_rise));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk(clk), .rst_n(rst_n), .raw_i(inc_btn), .db_o(inc_db), .rise_o(inc_rise));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
        .clk(clk), .rst_n(rst_n), .raw_i(dec_btn), .db_o(dec_db), .rise_o(dec_rise));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk(clk), .rst_n(rst_n), .raw_i(load_btn), .db_o(unused_load_db), .rise_o(load_rise));

    run_state_e        state_q, state_d;
    logic              run_q, run_d;
    logic [15:0]       step_cnt_q, step_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rep_fire;

    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cont_db)        state_d = ST_CONT;
                else if (step_rise) state_d = ST_STEP;
            end
            ST_STEP: begin
                step_cnt_d = step_cnt_q + 16'd1;
                state_d    = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                if (cont_db)       state_d = ST_CONT;
                else if (!step_db) state_d = ST_IDLE;
            end
            ST_CONT: begin
                if (!cont_db) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Decoding from the next state lines run_o up with the state it reflects.
        run_d = (state_d == ST_STEP) || (state_d == ST_CONT);
    end

`ifdef AUTO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DELAY + 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

    // After the first repeat the counter is rewound so later repeats come every REPEAT_PERIOD.
    always_comb begin
        rep_cnt_d = '0;
        rep_fire  = 1'b0;
        if (inc_db ^ dec_db) begin
            if (rep_cnt_q == REP_W'(REPEAT_DELAY)) begin
                rep_fire  = 1'b1;
                rep_cnt_d = REP_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);
            end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rep_cnt_q <= '0;
        else        rep_cnt_q <= rep_cnt_d;
    end
`else
    logic unused_rep_cfg;
    assign unused_rep_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
    assign rep_fire       = 1'b0;
`endif

    always_comb begin
        addr_d = addr_q;
        if (load_rise) begin
            addr_d = init_addr;
        end else if (inc_db && dec_db) begin
            addr_d = addr_q;
        end else if (inc_rise) begin
            addr_d = addr_q + ADDR_W'(1);
        end else if (dec_rise) begin
            addr_d = addr_q - ADDR_W'(1);
        end else if (rep_fire) begin
            addr_d = inc_db ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            run_q      <= 1'b0;
            step_cnt_q <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            step_cnt_q <= step_cnt_d;
            addr_q     <= addr_d;
        end
    end

    assign run_o      = run_q;
    assign addr_o     = addr_q;
    assign step_cnt_o = step_cnt_q;
    assign mode_o     = state_q;

endmodule

// File: tb/tb_ddu_ctrl.sv
// Self-checking bench for ddu_ctrl with short debounce/repeat timing.
`timescale 1ns/1ps
module tb_ddu_ctrl;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cont_sw, step_btn, inc_btn, dec_btn, load_btn;
    logic [AW-1:0] init_addr;
    logic          run_o;
    logic [AW-1:0] addr_o;
    logic [15:0]   step_cnt_o;
    logic [1:0]    mode_o;

    int n_cmp = 0;
    int n_mis = 0;
    int run_hi = 0;
    int exp_q[$];
    int model_addr;
    int base;

    ddu_ctrl #(
        .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cont_sw(cont_sw), .step_btn(step_btn),
        .inc_btn(inc_btn), .dec_btn(dec_btn), .load_btn(load_btn),
        .init_addr(init_addr), .run_o(run_o), .addr_o(addr_o),
        .step_cnt_o(step_cnt_o), .mode_o(mode_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n === 1'b1 && run_o === 1'b1) run_hi <= run_hi + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_addr(input int v);
        model_addr = v & 'hFF;
        exp_q.push_back(model_addr);
    endtask

    task automatic compare_addr(input string tag);
        if (exp_q.size() == 0) check_val({tag, "_noexp"}, 1, 0);
        else check_val(tag, int'(addr_o), exp_q.pop_front());
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: step_btn = v;
            1: inc_btn  = v;
            2: dec_btn  = v;
            default: load_btn = v;
        endcase
    endtask

    task automatic press(input int which, input int hold);
        set_btn(which, 1'b1);
        cyc(hold);
        set_btn(which, 1'b0);
        cyc(12);
    endtask

    // Debounced hold lasts as many cycles as the raw hold; repeats land at
    // offsets RD, RD+RP, ... counted from the rise cycle (offset 0).
    function automatic int reps(input int h);
`ifdef AUTO_REPEAT_EN
        return (h > RD) ? (h - 1 - RD) / RP + 1 : 0;
`else
        return 0;
`endif
    endfunction

    initial begin
        rst_n = 1'b0; cont_sw = 1'b0; step_btn = 1'b0; inc_btn = 1'b0;
        dec_btn = 1'b0; load_btn = 1'b0; init_addr = '0;
        cyc(3);
        check_val("rst_run", int'(run_o), 0);
        check_val("rst_addr", int'(addr_o), 0);
        check_val("rst_stepcnt", int'(step_cnt_o), 0);
        check_val("rst_mode", int'(mode_o), 0);
        rst_n = 1'b1;
        cyc(2);

        base = run_hi;
        step_btn = 1'b1; cyc(2); step_btn = 1'b0; cyc(20);
        check_val("glitch_run_pulses", run_hi - base, 0);
        check_val("glitch_stepcnt", int'(step_cnt_o), 0);
        check_val("glitch_mode", int'(mode_o), 0);

        base = run_hi;
        step_btn = 1'b1; cyc(10);
        check_val("step_hold_mode", int'(mode_o), 2);
        cyc(10);
        step_btn = 1'b0; cyc(3);
        check_val("step_rel_mode", int'(mode_o), 2);
        cyc(5);
        check_val("step_idle_mode", int'(mode_o), 0);
        check_val("step_run_pulses", run_hi - base, 1);
        check_val("step_stepcnt", int'(step_cnt_o), 1);

        cont_sw = 1'b1; cyc(10);
        check_val("cont_mode", int'(mode_o), 3);
        check_val("cont_run", int'(run_o), 1);
        base = run_hi;
        cyc(10);
        check_val("cont_run_cycles", run_hi - base, 10);
        press(0, 10);
        check_val("cont_step_ignored", int'(step_cnt_o), 1);
        check_val("cont_run_after_step", int'(run_o), 1);
        cont_sw = 1'b0; cyc(7);
        check_val("cont_off_run", int'(run_o), 0);
        check_val("cont_off_mode", int'(mode_o), 0);

        init_addr = 8'hFF;
        expect_addr('hFF); press(3, 8); compare_addr("load_ff");
        expect_addr(model_addr + 1); press(1, 8); compare_addr("inc_wrap");
        expect_addr(model_addr - 1); press(2, 8); compare_addr("dec_wrap");

        expect_addr(model_addr + 1 + reps(30));
        press(1, 30);
        compare_addr("inc_hold30");

        expect_addr(model_addr + 1);
        inc_btn = 1'b1; cyc(2);
        dec_btn = 1'b1; cyc(30);
        inc_btn = 1'b0; dec_btn = 1'b0; cyc(12);
        compare_addr("inc_dec_both");

        init_addr = 8'h5A;
        inc_btn = 1'b1; cyc(8);
        load_btn = 1'b1; cyc(7);
        expect_addr('h5A); compare_addr("load_during_inc");
        load_btn = 1'b0; cyc(5);
        inc_btn = 1'b0;
        expect_addr('h5A + reps(20));
        cyc(12);
        compare_addr("load_inc_final");

        init_addr = 8'h42;
        expect_addr('h42); press(3, 8); compare_addr("load_42");
        cont_sw = 1'b1; cyc(10);
        check_val("pre_rst_mode", int'(mode_o), 3);
        @(negedge clk); #1;
        rst_n = 1'b0; #1;
        check_val("async_rst_run", int'(run_o), 0);
        check_val("async_rst_addr", int'(addr_o), 0);
        check_val("async_rst_mode", int'(mode_o), 0);
        check_val("async_rst_stepcnt", int'(step_cnt_o), 0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (mode_o == 2'd3) break;
            cyc(1);
        end
        check_val("post_rst_cont_mode", int'(mode_o), 3);
        check_val("post_rst_run", int'(run_o), 1);
        check_val("post_rst_addr", int'(addr_o), 0);
        cont_sw = 1'b0; cyc(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
